reg_access_ctrl: RTL and testbench

Register-file access controller between the decode stage and the `registers` block, feeding the ALU operand inputs. It accepts one decoded read request (rs1, rs2) per handshake and arbitrates the register file's shared num1 port between writeback and operand reads. It forwards in-flight writeback data so operands are never stale, and presents operands to the execute stage with a valid/ready handshake.

---
 rtl/reg_access_ctrl_pkg.sv | 16 +
 rtl/reg_access_ctrl_operand_forward_mux.sv | 24 ++
 rtl/reg_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_access_ctrl_pkg.sv
// rtl/reg_access_ctrl_pkg.sv - shared sizes and state encoding for the register access controller
package reg_access_ctrl_pkg;

  localparam int WORD_SIZE     = 8;
  localparam int REG_ADDR_SIZE = 3;
  localparam int REG_NUM       = 8;

  // IDLE: waiting for a request; READ: register file read in flight;
  // VALID: operands presented to execute.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

endpackage

// File: rtl/reg_access_ctrl_operand_forward_mux.sv
// rtl/reg_access_ctrl_operand_forward_mux.sv - per-operand priority select between live writeback, forwarded data and register file data
module reg_access_ctrl_operand_forward_mux #(
  parameter int WORD_SIZE = reg_access_ctrl_pkg::WORD_SIZE
) (
  input  logic                 wb_hit,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 fwd_flag,
  input  logic [WORD_SIZE-1:0] fwd_data,
  input  logic [WORD_SIZE-1:0] rf_data,
  output logic [WORD_SIZE-1:0] data
);

  // A write landing this cycle is newest; a write seen at accept time beats
  // the register file, which returned the pre-write value.
  always_comb begin
    data = rf_data;
    if (wb_hit) begin
      data = wb_data;
    end else if (fwd_flag) begin
      data = fwd_data;
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - register file access arbiter with writeback forwarding and operand handshake
module reg_access_ctrl #(
  parameter int WORD_SIZE     = reg_access_ctrl_pkg::WORD_SIZE,
  parameter int REG_ADDR_SIZE = reg_access_ctrl_pkg::REG_ADDR_SIZE
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [REG_ADDR_SIZE-1:0] dec_rs1,
  input  logic [REG_ADDR_SIZE-1:0] dec_rs2,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_SIZE-1:0] wb_addr,
  input  logic [WORD_SIZE-1:0]     wb_data,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [WORD_SIZE-1:0]     op_a,
  output logic [WORD_SIZE-1:0]     op_b,
  output logic [REG_ADDR_SIZE-1:0] rf_num1,
  output logic [REG_ADDR_SIZE-1:0] rf_num2,
  output logic [WORD_SIZE-1:0]     rf_set_val,
  output logic                     rf_get_enable,
  output logic                     rf_set_enable,
  output logic                     rf_reset_enable,
  input  logic [WORD_SIZE-1:0]     rf_out1,
  input  logic [WORD_SIZE-1:0]     rf_out2
);

  import reg_access_ctrl_pkg::*;

  state_t                   state;
  state_t                   state_nxt;
  logic                     port_ok;
  logic                     accept;
  logic [REG_ADDR_SIZE-1:0] rs1_q;
  logic [REG_ADDR_SIZE-1:0] rs2_q;
  logic                     fwd1_q;
  logic                     fwd2_q;
  logic [WORD_SIZE-1:0]     fwd1_data_q;
  logic [WORD_SIZE-1:0]     fwd2_data_q;
  logic [WORD_SIZE-1:0]     op_a_q;
  logic [WORD_SIZE-1:0]     op_b_q;
  logic                     wb_hit1;
  logic                     wb_hit2;
  logic [WORD_SIZE-1:0]     mux_a;
  logic [WORD_SIZE-1:0]     mux_b;

  // num1 is shared: writeback owns it, so a read can only go out alongside
  // a write when both target the same register.
  assign port_ok = !wb_valid || (wb_addr == dec_rs1);

  assign wb_hit1 = wb_valid && (wb_addr == rs1_q);
  assign wb_hit2 = wb_valid && (wb_addr == rs2_q);

  assign rf_num1         = wb_valid ? wb_addr : dec_rs1;
  assign rf_num2         = dec_rs2;
  assign rf_set_val      = wb_data;
  assign rf_get_enable   = accept;
  assign rf_set_enable   = wb_valid && reset_n;
  assign rf_reset_enable = clear && reset_n;

  assign op_valid = (state == VALID);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, decode handshake and read strobe.
  always_comb begin
    state_nxt = state;
    dec_ready = 1'b0;
    case (state)
      IDLE: begin
        dec_ready = !clear && port_ok;
      end
      READ: begin
        state_nxt = VALID;
      end
      VALID: begin
        dec_ready = op_ready && !clear && port_ok;
        if (op_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    dec_ready = dec_ready && reset_n;
    accept    = dec_valid && dec_ready;
    if (accept) begin
      state_nxt = READ;
    end
    if (clear) begin
      state_nxt = IDLE;
    end
  end

  reg_access_ctrl_operand_forward_mux #(.WORD_SIZE(WORD_SIZE)) u_mux_a (
    .wb_hit   (wb_hit1),
    .wb_data  (wb_data),
    .fwd_flag (fwd1_q),
    .fwd_data (fwd1_data_q),
    .rf_data  (rf_out1),
    .data     (mux_a)
  );

  reg_access_ctrl_operand_forward_mux #(.WORD_SIZE(WORD_SIZE)) u_mux_b (
    .wb_hit   (wb_hit2),
    .wb_data  (wb_data),
    .fwd_flag (fwd2_q),
    .fwd_data (fwd2_data_q),
    .rf_data  (rf_out2),
    .data     (mux_b)
  );

  // Request capture, operand load after the read, and in-place refresh of
  // held operands so they never go stale while execute stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd1_data_q <= '0;
      fwd2_data_q <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else if (clear) begin
      fwd1_q <= 1'b0;
      fwd2_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      if (accept) begin
        rs1_q       <= dec_rs1;
        rs2_q       <= dec_rs2;
        fwd1_q      <= wb_valid && (wb_addr == dec_rs1);
        fwd2_q      <= wb_valid && (wb_addr == dec_rs2);
        fwd1_data_q <= wb_data;
        fwd2_data_q <= wb_data;
      end
      if (state == READ) begin
        op_a_q <= mux_a;
        op_b_q <= mux_b;
      end else if (state == VALID && !op_ready) begin
        if (wb_hit1) begin
          op_a_q <= wb_data;
        end
        if (wb_hit2) begin
          op_b_q <= wb_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - scoreboard bench for reg_access_ctrl against an architectural register model
module tb_reg_access_ctrl;

  localparam int W = reg_access_ctrl_pkg::WORD_SIZE;
  localparam int A = reg_access_ctrl_pkg::REG_ADDR_SIZE;
  localparam int N = reg_access_ctrl_pkg::REG_NUM;

  logic         clock;
  logic         reset_n;
  logic         clear;
  logic         dec_valid;
  logic         dec_ready;
  logic [A-1:0] dec_rs1;
  logic [A-1:0] dec_rs2;
  logic         wb_valid;
  logic [A-1:0] wb_addr;
  logic [W-1:0] wb_data;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [A-1:0] rf_num1;
  logic [A-1:0] rf_num2;
  logic [W-1:0] rf_set_val;
  logic         rf_get_enable;
  logic         rf_set_enable;
  logic         rf_reset_enable;
  logic [W-1:0] rf_out1;
  logic [W-1:0] rf_out2;

  typedef struct {
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    int           cyc;
  } req_t;

  req_t         q[$];
  logic [W-1:0] arch [N];
  logic [W-1:0] rf_regs [N];
  int           checks;
  int           failures;
  int           cyc;
  logic         exp_valid;
  logic         exp_ready;
  logic         acc;

  reg_access_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .clear           (clear),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .wb_valid        (wb_valid),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_a            (op_a),
    .op_b            (op_b),
    .rf_num1         (rf_num1),
    .rf_num2         (rf_num2),
    .rf_set_val      (rf_set_val),
    .rf_get_enable   (rf_get_enable),
    .rf_set_enable   (rf_set_enable),
    .rf_reset_enable (rf_reset_enable),
    .rf_out1         (rf_out1),
    .rf_out2         (rf_out2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Register file environment: reads return the value before a same-edge write.
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) rf_regs[i] <= '0;
      rf_out1 <= '0;
      rf_out2 <= '0;
    end else begin
      if (rf_get_enable) begin
        rf_out1 <= rf_regs[rf_num1];
        rf_out2 <= rf_regs[rf_num2];
      end
      if (rf_reset_enable) for (int i = 0; i < N; i++) rf_regs[i] <= '0;
      if (rf_set_enable) rf_regs[rf_num1] <= rf_set_val;
    end
  end

  // Monitor and scoreboard: operands must equal the architectural register
  // contents at every cycle they are presented.
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) arch[i] = '0;
      q.delete();
      chk("rst_op_valid", int'(op_valid), 0);
      chk("rst_op_a", int'(op_a), 0);
      chk("rst_op_b", int'(op_b), 0);
      chk("rst_get_en", int'(rf_get_enable), 0);
      chk("rst_set_en", int'(rf_set_enable), 0);
      chk("rst_reset_en", int'(rf_reset_enable), 0);
    end else begin
      exp_valid = (q.size() > 0) && (cyc >= q[0].cyc + 2);
      chk("op_valid", int'(op_valid), int'(exp_valid));
      if (op_valid && q.size() > 0) begin
        chk("op_a", int'(op_a), int'(arch[q[0].rs1]));
        chk("op_b", int'(op_b), int'(arch[q[0].rs2]));
      end
      exp_ready = !clear && (!wb_valid || wb_addr == dec_rs1) &&
                  (q.size() == 0 || (exp_valid && op_ready));
      chk("dec_ready", int'(dec_ready), int'(exp_ready));
      acc = dec_valid && dec_ready;
      chk("rf_get_enable", int'(rf_get_enable), int'(acc));
      chk("rf_num1", int'(rf_num1), wb_valid ? int'(wb_addr) : int'(dec_rs1));
      chk("rf_num2", int'(rf_num2), int'(dec_rs2));
      chk("rf_set_enable", int'(rf_set_enable), int'(wb_valid));
      chk("rf_reset_enable", int'(rf_reset_enable), int'(clear));
      chk("rf_set_val", int'(rf_set_val), int'(wb_data));
      if (op_valid && op_ready && q.size() > 0) void'(q.pop_front());
      if (clear) q.delete();
      if (acc) q.push_back('{rs1: dec_rs1, rs2: dec_rs2, cyc: cyc});
      if (clear) for (int i = 0; i < N; i++) arch[i] = '0;
      if (wb_valid) arch[wb_addr] = wb_data;
    end
  end

  task automatic drive(input logic dv, input logic [A-1:0] r1, input logic [A-1:0] r2,
                       input logic wv, input logic [A-1:0] wa, input logic [W-1:0] wd,
                       input logic clr, input logic rdy);
    @(posedge clock);
    #1;
    dec_valid = dv;
    dec_rs1   = r1;
    dec_rs2   = r2;
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
    clear     = clr;
    op_ready  = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    reset_n   = 1'b0;
    dec_valid = 1'b1;
    dec_rs1   = 3'd1;
    dec_rs2   = 3'd2;
    wb_valid  = 1'b1;
    wb_addr   = 3'd1;
    wb_data   = 8'hAA;
    clear     = 1'b1;
    op_ready  = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    reset_n = 1'b1;
    dec_valid = 1'b0;
    wb_valid  = 1'b0;
    clear     = 1'b0;

    // Writes then a plain read
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 8'h5A, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 8'h11, 1'b0, 1'b1);
    drive(1'b1, 3'd3, 3'd6, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    idle(3);

    // Port conflict: writeback to another register stalls the read
    drive(1'b1, 3'd2, 3'd0, 1'b1, 3'd5, 8'h33, 1'b0, 1'b1);
    drive(1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    idle(3);

    // Same-cycle forward with rs1 == rs2
    drive(1'b1, 3'd4, 3'd4, 1'b1, 3'd4, 8'hC7, 1'b0, 1'b1);
    idle(3);

    // Hold with in-place update of op_b
    drive(1'b1, 3'd3, 3'd6, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 8'h99, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    idle(3);

    // Back-to-back requests with execute always ready
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 3'(i), 3'(7 - i), 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    end
    idle(3);

    // Clear in the read cycle together with a write to r1
    drive(1'b1, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 8'h0F, 1'b1, 1'b1);
    idle(2);
    drive(1'b1, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [A-1:0] r1;
      logic [A-1:0] wa;
      r1 = 3'($urandom_range(0, N - 1));
      wa = ($urandom_range(0, 1) == 0) ? r1 : 3'($urandom_range(0, N - 1));
      drive($urandom_range(0, 99) < 60, r1, 3'($urandom_range(0, N - 1)),
            $urandom_range(0, 99) < 40, wa, 8'($urandom),
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60);
    end
    idle(4);
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
